// File: rtl/hash_table_pkg.sv
// Shared definitions for the hash table front end: op encodings,
// arbiter FSM states and small width helpers.
package hash_table_pkg;

    localparam int OP_W = 2;

    typedef enum logic [1:0] {
        OP_INSERT  = 2'b00,
        OP_DELETE  = 2'b01,
        OP_SEARCH  = 2'b10,
        OP_ILLEGAL = 2'b11
    } ht_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Bits needed to index n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hash_table_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or above the pointer,
// wrapping around, returned as a one-hot grant plus its index.
module rr_arbiter
    import hash_table_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int cand;

    // Scan from the pointer upward with wrap; the first hit wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (!any && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hash_table_arbiter.sv
// Shares one hash_table among NUM_REQ requesters: round-robin accept,
// issue one table op, wait for completion under a watchdog, then route
// the result back to the requester that issued it.
module hash_table_arbiter
    import hash_table_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [2*NUM_REQ-1:0]           req_op,
    input  logic [KEY_WIDTH*NUM_REQ-1:0]   req_key,
    input  logic [VALUE_WIDTH*NUM_REQ-1:0] req_value,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [VALUE_WIDTH-1:0]         rsp_value,
    output logic                           rsp_error,
    output logic                           rsp_timeout,
    output logic                           ht_op_en,
    output logic [1:0]                     ht_op_sel,
    output logic [KEY_WIDTH-1:0]           ht_key,
    output logic [VALUE_WIDTH-1:0]         ht_value,
    input  logic [VALUE_WIDTH-1:0]         ht_value_out,
    input  logic                           ht_op_done,
    input  logic                           ht_op_error,
    output logic                           busy
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = idx_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_e               state_q,     state_d;
    logic [IDX_W-1:0]         rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]         owner_q,     owner_d;
    logic [CNT_W-1:0]         cnt_q,       cnt_d;
    logic [1:0]               op_q,        op_d;
    logic [KEY_WIDTH-1:0]     key_q,       key_d;
    logic [VALUE_WIDTH-1:0]   value_q,     value_d;
    logic [VALUE_WIDTH-1:0]   res_value_q, res_value_d;
    logic                     res_err_q,   res_err_d;
    logic                     res_tmo_q,   res_tmo_d;

    logic [NUM_REQ-1:0]       gnt;
    logic [IDX_W-1:0]         win_idx;
    logic                     win_any;
    logic [1:0]               win_op;
    logic [KEY_WIDTH-1:0]     win_key;
    logic [VALUE_WIDTH-1:0]   win_value;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (win_idx),
        .any (win_any)
    );

    assign win_op    = req_op[win_idx*OP_W +: OP_W];
    assign win_key   = req_key[win_idx*KEY_WIDTH +: KEY_WIDTH];
    assign win_value = req_value[win_idx*VALUE_WIDTH +: VALUE_WIDTH];

    // State and operand registers; reset abandons any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            key_q       <= '0;
            value_q     <= '0;
            res_value_q <= '0;
            res_err_q   <= 1'b0;
            res_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            key_q       <= key_d;
            value_q     <= value_d;
            res_value_q <= res_value_d;
            res_err_q   <= res_err_d;
            res_tmo_q   <= res_tmo_d;
        end
    end

    // Next-state logic: accept, issue, wait with watchdog, respond.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        key_d       = key_q;
        value_d     = value_q;
        res_value_d = res_value_q;
        res_err_d   = res_err_q;
        res_tmo_d   = res_tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    owner_d     = win_idx;
                    op_d        = win_op;
                    key_d       = win_key;
                    value_d     = win_value;
                    res_value_d = '0;
                    res_tmo_d   = 1'b0;
                    // Illegal ops never touch the table.
                    if (win_op == OP_ILLEGAL) begin
                        res_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        res_err_d = 1'b0;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Completion takes precedence over a watchdog expiry in the same cycle.
                if (ht_op_done) begin
                    res_value_d = (op_q == OP_SEARCH) ? ht_value_out : '0;
                    res_err_d   = ht_op_error;
                    res_tmo_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_value_d = '0;
                    res_err_d   = 1'b1;
                    res_tmo_d   = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                // Owner drops to lowest priority for the next round.
                rr_ptr_d = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; response fields are forced to zero outside RESP.
    always_comb begin
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_value   = '0;
        rsp_error   = 1'b0;
        rsp_timeout = 1'b0;
        if (state_q == ST_IDLE && !rst) begin
            req_ready = gnt;
        end
        if (state_q == ST_RESP) begin
            rsp_valid   = NUM_REQ'(1) << owner_q;
            rsp_value   = res_value_q;
            rsp_error   = res_err_q;
            rsp_timeout = res_tmo_q;
        end
        ht_op_en  = (state_q == ST_ISSUE);
        ht_op_sel = op_q;
        ht_key    = key_q;
        ht_value  = value_q;
        busy      = (state_q != ST_IDLE);
    end

endmodule
